// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer
// and the logic units it feeds.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 6;

    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CAPTURE = 3'd3,
        SHOW    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button to single-cycle pulse:
// 2-flop synchroniser, debounce counter, rising-edge detect.
module btn_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_IN,
    output logic PULSE
);

    localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync    <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], BTN_IN};
            level_q <= level;
            // Level flips only after a long enough run of disagreement
            if (sync[1] != level) begin
                if (cnt == CW'(DB_CYCLES)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign PULSE = level & ~level_q & ~RST;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps a shared switch bank through A, B and OP, then captures
// the downstream unit's result for display.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OPW       = DEF_OPW,
    parameter int DB_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW,
    input  logic             BTN_LOAD,
    input  logic             BTN_CLEAR,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OPW-1:0]   OP,
    input  logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] RESULT,
    output logic             VALID,
    output logic [2:0]       STATE
);

    logic load_p;
    logic clr_p;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_load (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_IN (BTN_LOAD),
        .PULSE  (load_p)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clear (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_IN (BTN_CLEAR),
        .PULSE  (clr_p)
    );

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             vld_q, vld_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        vld_d   = vld_q;
        if (clr_p) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (load_p) begin
                    a_d     = SW;
                    state_d = WAIT_B;
                end
                WAIT_B: if (load_p) begin
                    b_d     = SW;
                    state_d = WAIT_OP;
                end
                WAIT_OP: if (load_p) begin
                    op_d    = SW[OPW-1:0];
                    state_d = CAPTURE;
                end
                // Z has had a full cycle to settle on the new OP
                CAPTURE: begin
                    res_d   = Z;
                    vld_d   = 1'b1;
                    state_d = SHOW;
                end
                SHOW: if (load_p) begin
                    a_d     = SW;
                    vld_d   = 1'b0;
                    state_d = WAIT_B;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign OP     = op_q;
    assign RESULT = res_q;
    assign VALID  = vld_q;
    assign STATE  = state_q;

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Upstream operand stage for the 8-bit logic/ALU units, such as the NOR unit, on the lab board. It takes one shared switch bank and a LOAD push-button, and steps through the sequence A → B → OP. It holds A, B and OP stable on registered outputs that feed the combinational unit. It then captures that unit's result Z into a registered RESULT with a VALID flag for the display and LED stage.

## Interface

Parameters:
- WIDTH, 8: operand and result width.
- OPW, 6: opcode width, taken from SW[OPW-1:0].
- DB_CYCLES, 4: debounce stability count in clocks. Use 4 in simulation; the board build overrides it to 1_000_000.

Ports:
- CLK, input, 1: the single clock. All state updates on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- SW, input, WIDTH: raw switch bank. Sampled only on a load pulse; no synchroniser.
- BTN_LOAD, input, 1: raw, asynchronous, bouncing push-button.
- BTN_CLEAR, input, 1: raw, asynchronous, bouncing push-button.
- A, output, WIDTH: registered operand A, fed to the logic unit.
- B, output, WIDTH: registered operand B.
- OP, output, OPW: registered opcode.
- Z, input, WIDTH: combinational result from the downstream unit.
- RESULT, output, WIDTH: registered copy of Z.
- VALID, output, 1: high while RESULT corresponds to the current A/B/OP.
- STATE, output, 3: current FSM state, for the debug LEDs.

## Operation

- **Button conditioning.** Each button passes through a 2-flop synchroniser, then a debouncer, then a rising-edge detector.
  - The debounced level changes only after the synchronised value has differed from it for DB_CYCLES consecutive clocks.
  - A rising edge of the debounced level yields a 1-cycle pulse: LOAD_P or CLR_P.
- **FSM states:** WAIT_A=0, WAIT_B=1, WAIT_OP=2, CAPTURE=3, SHOW=4.
- **Transitions:**
  - WAIT_A + LOAD_P: A<=SW, go to WAIT_B.
  - WAIT_B + LOAD_P: B<=SW, go to WAIT_OP.
  - WAIT_OP + LOAD_P: OP<=SW[OPW-1:0], go to CAPTURE.
  - CAPTURE: unconditional. RESULT<=Z, VALID<=1, go to SHOW. This cycle lets Z settle on the new OP.
  - SHOW + LOAD_P: A<=SW, VALID<=0, go to WAIT_B. This starts a new operation; B, OP and RESULT keep their old values until overwritten.
  - Any state without a pulse: hold state and all registers.
- **Clear.** CLR_P in any state sets A, B, OP and RESULT to 0, VALID to 0, and the state to WAIT_A.
- **Simultaneous events.**
  - CLR_P and LOAD_P in the same cycle: clear wins and the load is discarded.
  - LOAD_P during CAPTURE is discarded, not queued.
- **Widths.** Z is captured verbatim; no sign or overflow handling. SW bits above OPW-1 are ignored for OP.

## Timing

- **Reset.** RST high at an edge forces, at that edge:
  - A, B, OP, RESULT = 0; VALID = 0; STATE = WAIT_A;
  - synchronisers, debounce counters and debounced levels = 0;
  - no pulse is generated while RST is asserted.
- **Reset mid-operation.** Same result as above from any state, including CAPTURE; the pending capture is lost.
- **Button latency.** A raw button sampled high at edge k, and stable, gives the debounced level high at edge k+2+DB_CYCLES. The pulse is high during the following cycle, so the register or state update lands at edge k+3+DB_CYCLES.
- **Result latency.** RESULT and VALID update exactly 1 edge after OP.
- **Holding a button** produces exactly one pulse. Bounces shorter than DB_CYCLES produce none.
- **VALID timing.** VALID falls on the same edge that A is reloaded from SHOW.

## Structure

- **Package alu_seq_pkg:**
  - state localparams: WAIT_A, WAIT_B, WAIT_OP, CAPTURE, SHOW (3-bit);
  - default WIDTH and OPW;
  - opcode constant OP_NOR = 6'b100111, shared with the ALU stage.
- **Sub-module btn_conditioner** (parameter DB_CYCLES; ports CLK, RST, BTN_IN, PULSE): synchroniser, debounce counter and edge detect. Instantiate it twice, once per button.
- **Top level:** the FSM plus the A, B, OP and RESULT registers.

## Test plan

All scenarios use DB_CYCLES=4, with the bench connecting Z to the NOR unit.

- **Full sequence.** Load SW=0xCC, then 0xF0, then OP_NOR, waiting for each pulse. A=0xCC, B=0xF0, OP=0x27, RESULT=0x03, VALID=1 one edge after OP; STATE walks 0, 1, 2, 3, 4.
- **Latency.** Raise BTN_LOAD at edge k and hold it for 20 cycles. A changes exactly at edge k+7; no second load occurs.
- **Bounce rejection.** Toggle BTN_LOAD high 2 cycles, low 1, high 3, low 10. No pulse; STATE stays WAIT_A.
- **Restart from SHOW.** From SHOW with RESULT=0x03, load SW=0x0F. VALID=0, A=0x0F, STATE=WAIT_B, RESULT remains 0x03.
- **Clear precedence.** Make the CLR and LOAD pulses coincide while in WAIT_OP. All registers=0, STATE=WAIT_A, OP not loaded.
- **Reset mid-operation.** Assert RST for 1 cycle during CAPTURE. Every output is 0 at that edge; no RESULT update follows.
